// File: rtl/fft_butterfly.sv
// Radix-2 DIT complex butterfly in signed Q1.(DATA_WIDTH-1): A' = A + B*W, B' = A - B*W, one registered cycle.
// Optional build macro FFT_BUTTERFLY_SCALE_EN applies a floor 1/2 scale to every sum before saturation.
module fft_butterfly #(
  parameter int DATA_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           en,
  input  logic signed [DATA_WIDTH-1:0]   data_a_real,
  input  logic signed [DATA_WIDTH-1:0]   data_a_imag,
  input  logic signed [DATA_WIDTH-1:0]   data_b_real,
  input  logic signed [DATA_WIDTH-1:0]   data_b_imag,
  input  logic signed [DATA_WIDTH-1:0]   twiddle_real,
  input  logic signed [DATA_WIDTH-1:0]   twiddle_imag,
  output logic signed [DATA_WIDTH-1:0]   out_a_real,
  output logic signed [DATA_WIDTH-1:0]   out_a_imag,
  output logic signed [DATA_WIDTH-1:0]   out_b_real,
  output logic signed [DATA_WIDTH-1:0]   out_b_imag
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int SW = PW + 1;
  localparam int RW = DATA_WIDTH + 2;
  localparam int AW = DATA_WIDTH + 3;

  localparam logic signed [SW-1:0] RND_HALF =
    {{(SW-DATA_WIDTH+1){1'b0}}, 1'b1, {(DATA_WIDTH-2){1'b0}}};
  localparam logic signed [AW-1:0] SAT_MAX =
    {{(AW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [AW-1:0] SAT_MIN =
    {{(AW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic signed [RW-1:0] round_q(input logic signed [SW-1:0] x);
    logic signed [SW-1:0] t;
    logic signed [SW-1:0] s;
    t = x + RND_HALF;
    s = t >>> (DATA_WIDTH - 1);
    return s[RW-1:0];
  endfunction

  function automatic logic signed [AW-1:0] scale(input logic signed [AW-1:0] x);
`ifdef FFT_BUTTERFLY_SCALE_EN
    return x >>> 1;
`else
    return x;
`endif
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] saturate(input logic signed [AW-1:0] x);
    if (x > SAT_MAX)
      return SAT_MAX[DATA_WIDTH-1:0];
    else if (x < SAT_MIN)
      return SAT_MIN[DATA_WIDTH-1:0];
    else
      return x[DATA_WIDTH-1:0];
  endfunction

  // Stage p0: full-precision products; operands widened so 0x8000*0x8000 stays exact.
  logic signed [PW-1:0] br_p0, bi_p0, wr_p0, wi_p0;
  logic signed [PW-1:0] p_rr_p0, p_ii_p0, p_ri_p0, p_ir_p0;
  logic signed [SW-1:0] pr_p0, pi_p0;
  logic signed [AW-1:0] ar_p0, ai_p0, pr_rnd_p0, pi_rnd_p0;
  logic signed [AW-1:0] sum_ar_p0, sum_ai_p0, sum_br_p0, sum_bi_p0;

  assign br_p0 = PW'(data_b_real);
  assign bi_p0 = PW'(data_b_imag);
  assign wr_p0 = PW'(twiddle_real);
  assign wi_p0 = PW'(twiddle_imag);

  assign p_rr_p0 = br_p0 * wr_p0;
  assign p_ii_p0 = bi_p0 * wi_p0;
  assign p_ri_p0 = br_p0 * wi_p0;
  assign p_ir_p0 = bi_p0 * wr_p0;

  assign pr_p0 = SW'(p_rr_p0) - SW'(p_ii_p0);
  assign pi_p0 = SW'(p_ri_p0) + SW'(p_ir_p0);

  assign pr_rnd_p0 = AW'(round_q(pr_p0));
  assign pi_rnd_p0 = AW'(round_q(pi_p0));
  assign ar_p0     = AW'(data_a_real);
  assign ai_p0     = AW'(data_a_imag);

  assign sum_ar_p0 = ar_p0 + pr_rnd_p0;
  assign sum_ai_p0 = ai_p0 + pi_rnd_p0;
  assign sum_br_p0 = ar_p0 - pr_rnd_p0;
  assign sum_bi_p0 = ai_p0 - pi_rnd_p0;

  // Stage p1: output registers, loaded only on enabled edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_a_real <= '0;
      out_a_imag <= '0;
      out_b_real <= '0;
      out_b_imag <= '0;
    end else if (en) begin
      out_a_real <= saturate(scale(sum_ar_p0));
      out_a_imag <= saturate(scale(sum_ai_p0));
      out_b_real <= saturate(scale(sum_br_p0));
      out_b_imag <= saturate(scale(sum_bi_p0));
    end
  end

endmodule

// File: tb/tb_fft_butterfly.sv
// Self-checking bench for fft_butterfly: spec vectors, reset, hold, back-to-back and random checks
// against an integer-arithmetic reference model.
module tb_fft_butterfly;

  logic clk = 1'b0;
  logic rst_n;
  logic en;
  logic signed [15:0] ar, ai, br, bi, wr, wi;
  logic [15:0] oar, oai, obr, obi;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ar, ai, br, bi, wr, wi;
    logic [15:0] ear, eai, ebr, ebi;
  } vec_t;

  vec_t tbl[5];

  fft_butterfly #(.DATA_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .data_a_real(ar), .data_a_imag(ai),
    .data_b_real(br), .data_b_imag(bi),
    .twiddle_real(wr), .twiddle_imag(wi),
    .out_a_real(oar), .out_a_imag(oai),
    .out_b_real(obr), .out_b_imag(obi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic [15:0] e0, input logic [15:0] e1,
                      input logic [15:0] e2, input logic [15:0] e3);
    chk({nm, ".a_re"}, oar, e0);
    chk({nm, ".a_im"}, oai, e1);
    chk({nm, ".b_re"}, obr, e2);
    chk({nm, ".b_im"}, obi, e3);
  endtask

  // Reference: exact integer math, round-half-up, optional floor halving, clamp.
  function automatic longint rnd(input longint x);
    return (x + 64'sd16384) >>> 15;
  endfunction

  function automatic logic [15:0] fin(input longint s);
    longint v;
    v = s;
`ifdef FFT_BUTTERFLY_SCALE_EN
    v = v >>> 1;
`endif
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  task automatic model(input logic signed [15:0] a_r, input logic signed [15:0] a_i,
                       input logic signed [15:0] b_r, input logic signed [15:0] b_i,
                       input logic signed [15:0] w_r, input logic signed [15:0] w_i,
                       output logic [15:0] e0, output logic [15:0] e1,
                       output logic [15:0] e2, output logic [15:0] e3);
    longint pr, pi;
    pr = rnd(longint'(b_r) * longint'(w_r) - longint'(b_i) * longint'(w_i));
    pi = rnd(longint'(b_r) * longint'(w_i) + longint'(b_i) * longint'(w_r));
    e0 = fin(longint'(a_r) + pr);
    e1 = fin(longint'(a_i) + pi);
    e2 = fin(longint'(a_r) - pr);
    e3 = fin(longint'(a_i) - pi);
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'h0000;
      default: return 16'($urandom());
    endcase
  endfunction

  task automatic drive_rand();
    ar = pick(); ai = pick(); br = pick(); bi = pick(); wr = pick(); wi = pick();
  endtask

  logic [15:0] e0, e1, e2, e3, h0, h1, h2, h3;

  initial begin
`ifdef FFT_BUTTERFLY_SCALE_EN
    tbl[0] = '{16'h7FFF, 16'h0000, 16'h4000, 16'h4000, 16'h5A82, 16'hA57E,
               16'h6D40, 16'h0000, 16'h12BE, 16'h0000};
    tbl[1] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000,
               16'h3000, 16'h0000, 16'h1000, 16'h0000};
    tbl[2] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0000, 16'h8000,
               16'h2400, 16'h0800, 16'h1C00, 16'h1800};
    tbl[3] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
               16'h3F80, 16'h7FFF, 16'h3F80, 16'hC17E};
    tbl[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
               16'hC000, 16'h4000, 16'hC000, 16'h8000};
`else
    tbl[0] = '{16'h7FFF, 16'h0000, 16'h4000, 16'h4000, 16'h5A82, 16'hA57E,
               16'h7FFF, 16'h0000, 16'h257D, 16'h0000};
    tbl[1] = '{16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000,
               16'h6000, 16'h0000, 16'h2000, 16'h0000};
    tbl[2] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800, 16'h0000, 16'h8000,
               16'h4800, 16'h1000, 16'h3800, 16'h3000};
    tbl[3] = '{16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00,
               16'h7F00, 16'h7FFF, 16'h7F00, 16'h82FC};
    tbl[4] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000,
               16'h8000, 16'h7FFF, 16'h8000, 16'h8000};
`endif

    // Reset with enable high and arbitrary inputs.
    rst_n = 1'b0;
    en = 1'b1;
    drive_rand();
    repeat (3) @(posedge clk);
    #1 chk4("reset", 16'h0, 16'h0, 16'h0, 16'h0);

    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // Directed vectors, one enable pulse each.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ar = tbl[i].ar; ai = tbl[i].ai; br = tbl[i].br;
      bi = tbl[i].bi; wr = tbl[i].wr; wi = tbl[i].wi;
      en = 1'b1;
      @(posedge clk);
      #1 chk4($sformatf("vec%0d", i), tbl[i].ear, tbl[i].eai, tbl[i].ebr, tbl[i].ebi);
      @(negedge clk);
      en = 1'b0;
    end

    // Hold: en low, inputs churn for 5 cycles.
    h0 = oar; h1 = oai; h2 = obr; h3 = obi;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      drive_rand();
      @(posedge clk);
      #1 chk4($sformatf("hold%0d", i), h0, h1, h2, h3);
    end

    // Back-to-back: new result every cycle, old value visible until the edge.
    @(negedge clk);
    en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      h0 = oar; h1 = oai; h2 = obr; h3 = obi;
      drive_rand();
      model(ar, ai, br, bi, wr, wi, e0, e1, e2, e3);
      #1 chk4($sformatf("b2b_pre%0d", i), h0, h1, h2, h3);
      @(posedge clk);
      #1 chk4($sformatf("b2b%0d", i), e0, e1, e2, e3);
      @(negedge clk);
    end
    en = 1'b0;

    // Asynchronous reset between edges, then held over an enabled edge.
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk4("async_rst", 16'h0, 16'h0, 16'h0, 16'h0);
    en = 1'b1;
    drive_rand();
    @(posedge clk);
    #1 chk4("rst_held", 16'h0, 16'h0, 16'h0, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;
    en = 1'b0;

    // Randomized pulses with random gaps against the model.
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      drive_rand();
      en = ($urandom_range(0, 3) != 0);
      h0 = oar; h1 = oai; h2 = obr; h3 = obi;
      model(ar, ai, br, bi, wr, wi, e0, e1, e2, e3);
      @(posedge clk);
      #1;
      if (en) chk4($sformatf("rand%0d", i), e0, e1, e2, e3);
      else    chk4($sformatf("rand_hold%0d", i), h0, h1, h2, h3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fft_butterfly.md
Name: fft_butterfly

Overview:
Radix-2 decimation-in-time complex butterfly for the FFT datapath, in signed Q1.15 fixed point.
- Computes A' = A + B·W and B' = A − B·W, where W is the twiddle factor supplied by the stage controller.
- Single-cycle registered compute element that each FFT stage instantiates between its memory read and write-back.

Parameters:
- DATA_WIDTH, 16, width of every real/imag operand and result; two's complement, Q1.(DATA_WIDTH−1).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- en  input  1  compute strobe; captures a result on the rising edge where it is high
- data_a_real  input  DATA_WIDTH  A real part
- data_a_imag  input  DATA_WIDTH  A imaginary part
- data_b_real  input  DATA_WIDTH  B real part
- data_b_imag  input  DATA_WIDTH  B imaginary part
- twiddle_real  input  DATA_WIDTH  W real part (cos)
- twiddle_imag  input  DATA_WIDTH  W imaginary part (−sin)
- out_a_real  output  DATA_WIDTH  A' real part, registered
- out_a_imag  output  DATA_WIDTH  A' imaginary part, registered
- out_b_real  output  DATA_WIDTH  B' real part, registered
- out_b_imag  output  DATA_WIDTH  B' imaginary part, registered

Behaviour:
- Clocking and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset value: all four outputs 0 while rst_n=0, including a reset asserted mid-operation; the result being computed is discarded.
- Compute: combinational from the inputs, with no internal state other than the output registers.
- Latency: 1 cycle. With en=1 at a rising edge, the outputs reflect the inputs sampled at that edge immediately after the edge.
- Hold: with en=0, the outputs keep their last value indefinitely.
- No handshake and no back-pressure. en may be held high for one new result per cycle.
- Product terms (full precision, 2·DATA_WIDTH-bit signed): pr = br·wr − bi·wi; pi = br·wi + bi·wr, each sum carried at 2·DATA_WIDTH+1 bits.
- Rounding: add 2^(DATA_WIDTH−2), then arithmetic-shift right by DATA_WIDTH−1. This is round-half-up, giving a DATA_WIDTH+2-bit value.
- Sums: sign-extend A to DATA_WIDTH+3 bits. Compute ar+pr, ai+pi, ar−pr, ai−pi.
- Saturation: clamp each result to [−2^(DATA_WIDTH−1), 2^(DATA_WIDTH−1)−1], i.e. 0x8000 / 0x7FFF at 16 bits. There is never wrap-around.
- Corner cases:
  - 0x8000·0x8000 is computed exactly, with no overflow in the product stage.
  - W = 0x7FFF is treated as ≈1.0; its rounding error is absorbed by the round step.
- Inputs are sampled only at the enabled edge. Input changes while en=0 have no effect on the outputs.

Optional Feature:
- Macro: FFT_BUTTERFLY_SCALE_EN
- Defined: each of the four sums is arithmetic-shifted right by 1 (floor) before saturation. This is per-stage 1/2 scaling for block-scaled FFTs; saturation logic remains in place.
- Undefined: no scaling; results are saturated as described above.
- Latency and reset behaviour are identical in both builds.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs and en=1 -> all outputs 0x0000. Assert rst_n=0 mid-stream after a valid result -> outputs go to 0 immediately, without waiting for a clock edge.
- A=7FFF+0000i, B=4000+4000i, W=5A82+A57Ei, en pulse for 1 cycle -> out_a=7FFF+0000i (saturated), out_b=257D+0000i. With FFT_BUTTERFLY_SCALE_EN: out_a=6D40+0000i, out_b=12BE+0000i.
- A=4000+0000i, B=2000+0000i, W=7FFF+0000i -> out_a=6000+0000i, out_b=2000+0000i.
- A=4000+2000i, B=1000+0800i, W=0000+8000i -> out_a=4800+1000i, out_b=3800+3000i.
- All inputs 7F00 -> out_a=7F00+7FFFi (imag saturated), out_b=7F00+82FCi.
- Hold: after any case, keep en=0 and change every input for 5 cycles -> outputs unchanged. Then hold en=1 for back-to-back vectors -> one new result per cycle, each 1 cycle after its vector.
